rol_iter: RTL and testbench



---
 rtl/rol_iter.sv | 111 +++++++++++
 tb/tb_rol_iter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rol_iter.sv
// -----------------------------------------------------------------------------
// rol_iter
// Iterative rotate-left unit for the extended-ALU path. A 32-bit operand is
// rotated left by a 5-bit amount, one step per clock. A start/busy/done
// handshake reports progress and completion.
//
// Optional feature macro: ROL_ITER_STEP4_EN
//   When this macro is defined, RUN rotates by 4 while at least 4 positions
//   remain, and by 1 otherwise. The result is identical in both builds; only
//   the latency changes.
//
// Ports
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous reset, active-high
//   start    in   1  request, accepted in IDLE or DONE
//   in_1     in  32  operand, sampled on the accepting edge
//   in_2     in  32  rotate amount, only [4:0] used, sampled on accepting edge
//   busy     out  1  high while the rotate is in progress
//   done     out  1  one-cycle completion pulse
//   out_rol  out 32  result register, held until next completion or reset
// -----------------------------------------------------------------------------
module rol_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] in_1,
    input  logic [31:0] in_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out_rol
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    // Only the low five bits of the amount matter. The upper bits are folded
    // into a sink so that they are visibly, and intentionally, ignored.
    logic unused_in2;
    assign unused_in2 = ^in_2[31:5];

    // State register. Reset takes priority over every other action.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state logic. Starting from DONE captures new operands in the same
    // way as starting from IDLE, which lets operations run back to back.
    // The result register loads only at the point of completion.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    data_d  = in_1;
                    cnt_d   = in_2[4:0];
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == 5'd0) begin
                    result_d = data_q;
                    state_d  = DONE;
                end else begin
`ifdef ROL_ITER_STEP4_EN
                    if (cnt_q >= 5'd4) begin
                        data_d = {data_q[27:0], data_q[31:28]};
                        cnt_d  = cnt_q - 5'd4;
                    end else begin
                        data_d = {data_q[30:0], data_q[31]};
                        cnt_d  = cnt_q - 5'd1;
                    end
`else
                    data_d = {data_q[30:0], data_q[31]};
                    cnt_d  = cnt_q - 5'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign out_rol = result_q;

endmodule

// File: tb/tb_rol_iter.sv
// -----------------------------------------------------------------------------
// tb_rol_iter
// Directed testbench for rol_iter. Each scenario task drives its own
// stimulus and checks against hand-computed values. Expected latency follows
// the ROL_ITER_STEP4_EN macro in the same way as the design.
// -----------------------------------------------------------------------------
module tb_rol_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        busy;
    logic        done;
    logic [31:0] out_rol;

    int nCompared;
    int nMismatched;

    rol_iter dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_1    (in_1),
        .in_2    (in_2),
        .busy    (busy),
        .done    (done),
        .out_rol (out_rol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of edges after E0 at which done rises, for rotate amount n.
    function automatic int lat(input int n);
`ifdef ROL_ITER_STEP4_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    // Presents operands with a single-cycle start pulse. Then counts edges
    // until done rises, and counts cycles in which busy is high. The wait is
    // bounded, and running out of cycles sets timedOut.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 output int cyc, output int busyCnt,
                                 output bit timedOut);
        @(negedge clk);
        start = 1'b1;
        in_1  = a;
        in_2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_1  = 32'hDEADBEEF;
        in_2  = 32'h0000001F;
        busyCnt  = busy ? 1 : 0;
        cyc      = 0;
        timedOut = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busyCnt++;
        end
        if (!done) timedOut = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || out_rol !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset: busy=%b done=%b out=%h required 0/0/00000000",
                     busy, done, out_rol);
        end
    endtask

    task automatic test_rol1();
        int cyc, bc;
        bit to;
        applyStimulus(32'h80000001, 32'd1, cyc, bc, to);
        nCompared++;
        if (to || cyc !== lat(1)) begin
            nMismatched++;
            $display("[TB] FAIL rol1_latency: got %0d required %0d", cyc, lat(1));
        end
        nCompared++;
        if (out_rol !== 32'h00000003) begin
            nMismatched++;
            $display("[TB] FAIL rol1_result: got %h required 00000003", out_rol);
        end
        nCompared++;
        if (bc !== lat(1)) begin
            nMismatched++;
            $display("[TB] FAIL rol1_busy_cycles: got %0d required %0d", bc, lat(1));
        end
        // done is a single-cycle pulse, and the result holds after it
        @(posedge clk);
        #1;
        nCompared++;
        if (done !== 1'b0 || busy !== 1'b0 || out_rol !== 32'h00000003) begin
            nMismatched++;
            $display("[TB] FAIL rol1_after_done: done=%b busy=%b out=%h required 0/0/00000003",
                     done, busy, out_rol);
        end
    endtask

    task automatic test_zero();
        int cyc, bc;
        bit to;
        applyStimulus(32'h12345678, 32'd0, cyc, bc, to);
        nCompared++;
        if (to || cyc !== 1) begin
            nMismatched++;
            $display("[TB] FAIL zero_latency: got %0d required 1", cyc);
        end
        nCompared++;
        if (out_rol !== 32'h12345678) begin
            nMismatched++;
            $display("[TB] FAIL zero_result: got %h required 12345678", out_rol);
        end
    endtask

    task automatic test_max();
        int cyc, bc;
        bit to;
        int expLat;
`ifdef ROL_ITER_STEP4_EN
        expLat = 11;
`else
        expLat = 32;
`endif
        applyStimulus(32'h00000001, 32'd31, cyc, bc, to);
        nCompared++;
        if (to || cyc !== expLat) begin
            nMismatched++;
            $display("[TB] FAIL max_latency: got %0d required %0d", cyc, expLat);
        end
        nCompared++;
        if (out_rol !== 32'h80000000) begin
            nMismatched++;
            $display("[TB] FAIL max_result: got %h required 80000000", out_rol);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        @(negedge clk);
        start = 1'b1;
        in_1  = 32'hF0000000;
        in_2  = 32'hFFFFFFE5;
        @(posedge clk);
        #1;
        start = 1'b0;
        // pulse start with other operands while the rotate is running
        @(negedge clk);
        start = 1'b1;
        in_1  = 32'hAAAA5555;
        in_2  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        nCompared++;
        if (!done || cyc !== lat(5)) begin
            nMismatched++;
            $display("[TB] FAIL ignore_latency: got %0d required %0d", cyc, lat(5));
        end
        nCompared++;
        if (out_rol !== 32'h0000001E) begin
            nMismatched++;
            $display("[TB] FAIL ignore_result: got %h required 0000001E", out_rol);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        start = 1'b1;
        in_1  = 32'h0000000F;
        in_2  = 32'd4;
        @(posedge clk);
        #1;
        in_2 = 32'd8;
        cyc  = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        nCompared++;
        if (!done || cyc !== lat(4)) begin
            nMismatched++;
            $display("[TB] FAIL b2b_first_latency: got %0d required %0d", cyc, lat(4));
        end
        nCompared++;
        if (out_rol !== 32'h000000F0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_first_result: got %h required 000000F0", out_rol);
        end
        // start is still high, so DONE goes straight back to RUN
        @(posedge clk);
        #1;
        start = 1'b0;
        nCompared++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_no_idle: busy=%b done=%b required 1/0", busy, done);
        end
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        nCompared++;
        if (!done || cyc !== lat(8)) begin
            nMismatched++;
            $display("[TB] FAIL b2b_second_latency: got %0d required %0d", cyc, lat(8));
        end
        nCompared++;
        if (out_rol !== 32'h00000F00) begin
            nMismatched++;
            $display("[TB] FAIL b2b_second_result: got %h required 00000F00", out_rol);
        end
    endtask

    task automatic test_reset_midrun();
        bit sawDone;
        @(negedge clk);
        start = 1'b1;
        in_1  = 32'h00000001;
        in_2  = 32'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || out_rol !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL midrun_reset: busy=%b done=%b out=%h required 0/0/00000000",
                     busy, done, out_rol);
        end
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) sawDone = 1'b1;
        end
        nCompared++;
        if (sawDone !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL midrun_no_done: activity seen after abort, required none");
        end
    endtask

    task automatic checkOutput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        in_1  = 32'd0;
        in_2  = 32'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_rol1();
        test_zero();
        test_max();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        checkOutput();
        $finish;
    end

endmodule
